// File: rtl/mul_seq_if.sv
// Request/result handshake bundle between an issuing pipeline and the
// multiply sequencer.
interface mul_seq_if #(parameter int TAG_W = 5);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [31:0]       req_a;
  logic [31:0]       req_b;
  logic [TAG_W-1:0]  req_tag;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [TAG_W-1:0]  res_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, res_ready,
    input  req_ready, res_valid, res_data, res_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, res_ready,
    output req_ready, res_valid, res_data, res_tag
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the 4-step 16x16 multiplier datapath: steps the datapath,
// returns the requested product half and caches the last full product.
module mul_seq_ctrl #(
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  mul_seq_if.slave    bus,
  output logic        busy,
  output logic [31:0] mul_ain,
  output logic [31:0] mul_bin,
  output logic        mul_ss,
  output logic        mul_su,
  output logic        mul_uu,
  output logic [1:0]  mul_state,
  input  logic [63:0] mul_prod
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {CLS_UU, CLS_SS, CLS_SU} cls_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       op_q;
  cls_t             cls_q, req_cls, ccls_q;
  logic [TAG_W-1:0] tag_q;
  logic             first_q;
  logic [31:0]      ca_q, cb_q;
  logic [63:0]      prod_q;
  logic             cvld_q;
  logic             accept, hit;
  logic [63:0]      p;

  always_comb begin
    req_cls = CLS_UU;
    if (bus.req_op == 2'b01)      req_cls = CLS_SS;
    else if (bus.req_op == 2'b10) req_cls = CLS_SU;
  end

  assign bus.req_ready = (state_q == IDLE) && !flush;
  assign accept        = bus.req_valid && bus.req_ready;
  assign hit           = CACHE_EN && cvld_q && (ca_q == bus.req_a) &&
                         (cb_q == bus.req_b) && (ccls_q == req_cls);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
              state_d = hit ? DONE : CALC;
              cnt_d   = 2'd0;
            end
      CALC: begin
              cnt_d = cnt_q + 2'd1;
              if (cnt_q == 2'd3) state_d = DONE;
            end
      DONE: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      op_q    <= 2'd0;
      cls_q   <= CLS_UU;
      tag_q   <= '0;
      mul_ain <= 32'd0;
      mul_bin <= 32'd0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // first_q marks the single DONE cycle where mul_prod is the live source
      first_q <= (state_q == CALC) && (state_d == DONE);
      if (accept) begin
        op_q    <= bus.req_op;
        cls_q   <= req_cls;
        tag_q   <= bus.req_tag;
        mul_ain <= bus.req_a;
        mul_bin <= bus.req_b;
      end
    end
  end

  // prod_q holds the datapath result for the rest of DONE and doubles as
  // the cache payload; the key and valid bit exist only with the cache on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= 64'd0;
      ca_q   <= 32'd0;
      cb_q   <= 32'd0;
      ccls_q <= CLS_UU;
      cvld_q <= 1'b0;
    end else if (state_q == DONE && first_q) begin
      prod_q <= mul_prod;
      if (CACHE_EN) begin
        ca_q   <= mul_ain;
        cb_q   <= mul_bin;
        ccls_q <= cls_q;
        cvld_q <= 1'b1;
      end
    end
  end

  assign p             = first_q ? mul_prod : prod_q;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = (state_q != DONE) ? 32'd0 :
                         (op_q == 2'b00)   ? p[31:0] : p[63:32];
  assign bus.res_tag   = tag_q;
  assign busy          = (state_q != IDLE);
  assign mul_state     = (state_q == CALC) ? cnt_q : 2'd0;
  assign mul_ss        = (state_q == CALC) && !flush && (cls_q == CLS_SS);
  assign mul_su        = (state_q == CALC) && !flush && (cls_q == CLS_SU);
  assign mul_uu        = (state_q == CALC) && !flush && (cls_q == CLS_UU);
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: behavioural multiplier model plus a result
// scoreboard of expected data, tag and latency.
module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] mul_ain, mul_bin;
  logic        mul_ss, mul_su, mul_uu;
  logic [1:0]  mul_state;
  logic [63:0] prod_r = 64'd0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          lat;
  } exp_t;
  exp_t sb[$];

  mul_seq_if #(.TAG_W(5)) bus ();

  mul_seq_ctrl #(.TAG_W(5), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .busy(busy),
    .mul_ain(mul_ain), .mul_bin(mul_bin), .mul_ss(mul_ss), .mul_su(mul_su),
    .mul_uu(mul_uu), .mul_state(mul_state), .mul_prod(prod_r)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mulf(input logic [31:0] a, input logic [31:0] b,
                                       input logic ss, input logic su);
    logic [63:0] ea, eb;
    ea = (ss || su) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = ss ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Registered datapath model: product appears after the last step
  always @(posedge clk)
    if ((mul_ss || mul_su || mul_uu) && mul_state == 2'd3)
      prod_r <= mulf(mul_ain, mul_bin, mul_ss, mul_su);

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] ed, input int lat,
                       input bit push);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: req_ready=%b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    if (push) sb.push_back('{ed, tag, lat});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic collect(input logic [1:0] op, input int hold);
    int cyc;
    exp_t e;
    logic [2:0] sel;
    logic [31:0] d0;
    logic [4:0]  t0;
    sel = (op == 2'b01) ? 3'b100 : (op == 2'b10) ? 3'b010 : 3'b001;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.res_valid === 1'b1) break;
      checks++;
      if (mul_state !== 2'(cyc - 1) || {mul_ss, mul_su, mul_uu} !== sel) begin
        errors++;
        $display("FAIL calc_step%0d: state=%0d sel=%b want state=%0d sel=%b",
                 cyc, mul_state, {mul_ss, mul_su, mul_uu}, cyc - 1, sel);
      end
    end
    e = sb.pop_front();
    checks++;
    if (cyc !== e.lat) begin
      errors++;
      $display("FAIL latency: got %0d cycles want %0d", cyc, e.lat);
    end
    checks++;
    if (bus.res_data !== e.data) begin
      errors++;
      $display("FAIL res_data: got %h want %h", bus.res_data, e.data);
    end
    checks++;
    if (bus.res_tag !== e.tag) begin
      errors++;
      $display("FAIL res_tag: got %0d want %0d", bus.res_tag, e.tag);
    end
    if (e.lat == 1) begin
      checks++;
      if (mul_state !== 2'd0 || {mul_ss, mul_su, mul_uu} !== 3'b000) begin
        errors++;
        $display("FAIL hit_idle_dp: state=%0d sel=%b want 0/000", mul_state,
                 {mul_ss, mul_su, mul_uu});
      end
    end
    d0 = bus.res_data; t0 = bus.res_tag;
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== d0 || bus.res_tag !== t0 ||
          bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: v=%b d=%h t=%0d rdy=%b want 1/%h/%0d/0",
                 bus.res_valid, bus.res_data, bus.res_tag, bus.req_ready, d0, t0);
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: res_valid=%b req_ready=%b want 0/1", bus.res_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== 32'd0 ||
        bus.res_tag !== 5'd0 || mul_state !== 2'd0 || mul_ain !== 32'd0 ||
        mul_bin !== 32'd0 || {mul_ss, mul_su, mul_uu} !== 3'b000) begin
      errors++;
      $display("FAIL reset_values: busy=%b v=%b d=%h t=%0d st=%0d a=%h b=%h sel=%b want all 0",
               busy, bus.res_valid, bus.res_data, bus.res_tag, mul_state, mul_ain, mul_bin,
               {mul_ss, mul_su, mul_uu});
    end
  endtask

  task automatic test_mul_basic;
    issue(2'b00, 32'd3, 32'd5, 5'd7, 32'h0000000F, 5, 1'b1);
    collect(2'b00, 0);
  endtask

  task automatic test_signed_modes;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000, 5, 1'b1);
    collect(2'b01, 0);
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 5, 1'b1);
    collect(2'b11, 0);
    issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 5, 1'b1);
    collect(2'b10, 0);
    issue(2'b01, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000, 5, 1'b1);
    collect(2'b01, 0);
  endtask

  task automatic test_cache;
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, 5, 1'b1);
    collect(2'b11, 0);
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000001, 1, 1'b1);
    collect(2'b00, 0);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h00000000, 5, 1'b1);
    collect(2'b01, 0);
  endtask

  task automatic test_backpressure;
    issue(2'b00, 32'd3, 32'd5, 5'd21, 32'h0000000F, 5, 1'b1);
    collect(2'b00, 4);
  endtask

  task automatic test_flush;
    int n;
    issue(2'b00, 32'd2, 32'd2, 5'd5, 32'd0, 5, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (mul_state !== 2'd2 && n < 10);
    checks++;
    if (mul_state !== 2'd2) begin
      errors++;
      $display("FAIL flush_reach_step2: state=%0d want 2", mul_state);
    end
    flush = 1'b1;
    #1;
    checks++;
    if ({mul_ss, mul_su, mul_uu} !== 3'b000) begin
      errors++;
      $display("FAIL flush_sel_now: sel=%b want 000", {mul_ss, mul_su, mul_uu});
    end
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || busy !== 1'b0 || mul_state !== 2'd0 ||
        {mul_ss, mul_su, mul_uu} !== 3'b000) begin
      errors++;
      $display("FAIL flush_idle: v=%b busy=%b st=%0d sel=%b want 0/0/0/000",
               bus.res_valid, busy, mul_state, {mul_ss, mul_su, mul_uu});
    end
    issue(2'b00, 32'd7, 32'd9, 5'd6, 32'h0000003F, 5, 1'b1);
    collect(2'b00, 0);
    @(negedge clk);
    flush = 1'b1;
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_a = 32'd1; bus.req_b = 32'd1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_ready: got %b want 0", bus.req_ready);
    end
    @(posedge clk);
    #1 flush = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_accept: busy=%b want 0", busy);
    end
    // 7x9 was cached by the completed request above
    issue(2'b00, 32'd7, 32'd9, 5'd8, 32'h0000003F, 1, 1'b1);
    collect(2'b00, 0);
  endtask

  task automatic test_async_reset;
    issue(2'b00, 32'd11, 32'd13, 5'd9, 32'd0, 5, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.res_valid !== 1'b0 || mul_state !== 2'd0 ||
        mul_ain !== 32'd0 || mul_bin !== 32'd0 || {mul_ss, mul_su, mul_uu} !== 3'b000 ||
        bus.res_data !== 32'd0 || bus.res_tag !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b v=%b st=%0d a=%h b=%h sel=%b d=%h t=%0d want all 0",
               busy, bus.res_valid, mul_state, mul_ain, mul_bin, {mul_ss, mul_su, mul_uu},
               bus.res_data, bus.res_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b00, 32'd7, 32'd9, 5'd13, 32'h0000003F, 5, 1'b1);
    collect(2'b00, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_a = 32'd0; bus.req_b = 32'd0;
    bus.req_tag = 5'd0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_mul_basic();
    test_signed_modes();
    test_cache();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
